// File: rtl/vector_add_seq_ctrl_if.sv
// Command, operand-read, adder-valid and destination-write signals of the
// vector_add_seq_ctrl block. The controller connects through the slave
// modport; the command issuer / buffer / adder side uses master.
interface vector_add_seq_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 12
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_a_base;
   logic [ADDR_W-1:0] cmd_b_base;
   logic [ADDR_W-1:0] cmd_d_base;
   logic [LEN_W-1:0]  cmd_len;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_a_addr;
   logic [ADDR_W-1:0] rd_b_addr;
   logic              add_in_valid;
   logic              add_out_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              done;
   logic              err;
   logic [31:0]       perf_cycles;

   modport slave (
      input  cmd_valid, cmd_a_base, cmd_b_base, cmd_d_base, cmd_len, add_out_valid,
      output cmd_ready, rd_en, rd_a_addr, rd_b_addr, add_in_valid,
             wr_en, wr_addr, done, err, perf_cycles
   );

   modport master (
      output cmd_valid, cmd_a_base, cmd_b_base, cmd_d_base, cmd_len, add_out_valid,
      input  cmd_ready, rd_en, rd_a_addr, rd_b_addr, add_in_valid,
             wr_en, wr_addr, done, err, perf_cycles
   );
endinterface

// File: rtl/vector_add_seq_ctrl.sv
// Job sequencer for the 16-lane fp32 vector_add pipeline: issues paired A/B
// row reads, delays the read strobe into the adder input valid, maps adder
// output valids onto destination write addresses and pulses done when every
// issued row has come back.
// Optional job cycle counter on perf_cycles: define VADD_SEQ_PERF_EN.
module vector_add_seq_ctrl #(
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 12,
   parameter int RD_LAT = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   vector_add_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [LEN_W:0] OUT_ONE = LEN_W'(1);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  a_base_q, a_base_d;
   logic [ADDR_W-1:0]  b_base_q, b_base_d;
   logic [ADDR_W-1:0]  d_base_q, d_base_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   issue_cnt_q, issue_cnt_d;
   logic [LEN_W-1:0]   wr_cnt_q, wr_cnt_d;
   logic [LEN_W:0]     outstanding_q, outstanding_d;
   logic [RD_LAT-1:0]  vld_sr_q, vld_sr_d;
   logic               err_q, err_d;
   logic               post_rst_q, post_rst_d;

   logic               accept;
   logic               rd_en;
   logic               wr_acc;
   logic               busy;

   // Next-state, counters, strobes and error detection
   always_comb begin
      state_d       = state_q;
      a_base_d      = a_base_q;
      b_base_d      = b_base_q;
      d_base_d      = d_base_q;
      len_d         = len_q;
      issue_cnt_d   = issue_cnt_q;
      wr_cnt_d      = wr_cnt_q;
      outstanding_d = outstanding_q;
      err_d         = err_q;
      post_rst_d    = post_rst_q;
      vld_sr_d      = '0;

      accept = bus.cmd_valid && (state_q == S_IDLE);
      rd_en  = (state_q == S_ISSUE);
      busy   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      wr_acc = bus.add_out_valid && busy && (outstanding_q != '0);

      vld_sr_d[0] = rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         vld_sr_d[i] = vld_sr_q[i-1];
      end

      unique case ({rd_en, wr_acc})
         2'b10:   outstanding_d = outstanding_q + OUT_ONE;
         2'b01:   outstanding_d = outstanding_q - OUT_ONE;
         default: outstanding_d = outstanding_q;
      endcase

      if (wr_acc) begin
         wr_cnt_d = wr_cnt_q + LEN_W'(1);
      end

      // Results still in the adder when reset aborted a job must not flag an
      // error: stray valids in IDLE are ignored until the next command.
      if (bus.add_out_valid && !wr_acc && !(post_rst_q && (state_q == S_IDLE))) begin
         err_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_base_d      = bus.cmd_a_base;
               b_base_d      = bus.cmd_b_base;
               d_base_d      = bus.cmd_d_base;
               len_d         = bus.cmd_len;
               issue_cnt_d   = '0;
               wr_cnt_d      = '0;
               outstanding_d = '0;
               post_rst_d    = 1'b0;
               state_d       = (bus.cmd_len == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue_cnt_d = issue_cnt_q + LEN_W'(1);
            if (issue_cnt_q == len_q - LEN_W'(1)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (wr_acc && (outstanding_q == OUT_ONE)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Controller state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         a_base_q      <= '0;
         b_base_q      <= '0;
         d_base_q      <= '0;
         len_q         <= '0;
         issue_cnt_q   <= '0;
         wr_cnt_q      <= '0;
         outstanding_q <= '0;
         vld_sr_q      <= '0;
         err_q         <= 1'b0;
         post_rst_q    <= 1'b1;
      end else begin
         state_q       <= state_d;
         a_base_q      <= a_base_d;
         b_base_q      <= b_base_d;
         d_base_q      <= d_base_d;
         len_q         <= len_d;
         issue_cnt_q   <= issue_cnt_d;
         wr_cnt_q      <= wr_cnt_d;
         outstanding_q <= outstanding_d;
         vld_sr_q      <= vld_sr_d;
         err_q         <= err_d;
         post_rst_q    <= post_rst_d;
      end
   end

   assign bus.cmd_ready    = (state_q == S_IDLE);
   assign bus.rd_en        = rd_en;
   assign bus.rd_a_addr    = a_base_q + ADDR_W'(issue_cnt_q);
   assign bus.rd_b_addr    = b_base_q + ADDR_W'(issue_cnt_q);
   assign bus.add_in_valid = vld_sr_q[RD_LAT-1];
   assign bus.wr_en        = wr_acc;
   assign bus.wr_addr      = d_base_q + ADDR_W'(wr_cnt_q);
   assign bus.done         = (state_q == S_DONE);
   assign bus.err          = err_q;

`ifdef VADD_SEQ_PERF_EN
   logic [31:0] perf_cnt_q, perf_cnt_d;
   logic [31:0] perf_q, perf_d;
   logic [31:0] perf_inc;

   // Saturating job cycle counter; value including the DONE cycle is latched
   always_comb begin
      perf_cnt_d = perf_cnt_q;
      perf_d     = perf_q;
      perf_inc   = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 32'd1;
      if (accept) begin
         perf_cnt_d = '0;
      end else if (state_q != S_IDLE) begin
         perf_cnt_d = perf_inc;
      end
      if (state_q == S_DONE) begin
         perf_d = perf_inc;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cnt_q <= '0;
         perf_q     <= '0;
      end else begin
         perf_cnt_q <= perf_cnt_d;
         perf_q     <= perf_d;
      end
   end

   assign bus.perf_cycles = perf_q;
`else
   assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_vector_add_seq_ctrl.sv
// Self-checking bench for vector_add_seq_ctrl: an 11-cycle adder valid model,
// a read/write address scoreboard and a table of jobs, plus hand-written
// sequences for spurious results, mid-job reset and back-to-back commands.
module tb_vector_add_seq_ctrl;

   localparam int ADDR_W = 12;
   localparam int LEN_W  = 12;
   localparam int ADD_LAT_IDX = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic inject = 1'b0;
   logic [ADD_LAT_IDX:0] pipe = '0;
   logic [1:0] rd_hist;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned acc_cnt = 0;
   int unsigned done_cnt = 0;
   int unsigned last_acc = 0;
   int unsigned last_done = 0;

   logic [23:0] rd_q[$];
   logic [11:0] wr_q[$];
   logic [23:0] e_rd;
   logic [11:0] e_wr;

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [11:0] d;
      logic [11:0] len;
      int unsigned done_lat;
   } job_t;

   job_t tbl[5];

   vector_add_seq_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   vector_add_seq_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // adder model: fixed 11-cycle valid latency, not affected by rst_n
   always @(posedge clk) pipe <= {pipe[ADD_LAT_IDX-1:0], bus.add_in_valid};
   assign bus.add_out_valid = pipe[ADD_LAT_IDX] | inject;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_hist <= '0;
      else        rd_hist <= {rd_hist[0], bus.rd_en};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
         acc_cnt++;
         last_acc = cyc;
      end
      if (bus.done) begin
         done_cnt++;
         last_done = cyc;
      end
      if (bus.rd_en) begin
         if (rd_q.size() == 0) chk("rd_unexpected", {31'd0, bus.rd_en}, 32'd0);
         else begin
            e_rd = rd_q.pop_front();
            chk("rd_addr", {8'd0, bus.rd_a_addr, bus.rd_b_addr}, {8'd0, e_rd});
         end
      end
      if (bus.wr_en) begin
         if (wr_q.size() == 0) chk("wr_unexpected", {31'd0, bus.wr_en}, 32'd0);
         else begin
            e_wr = wr_q.pop_front();
            chk("wr_addr", {20'd0, bus.wr_addr}, {20'd0, e_wr});
         end
      end
      if (bus.add_in_valid || rd_hist[1])
         chk("add_in_valid", {31'd0, bus.add_in_valid}, {31'd0, rd_hist[1]});
   end

   function automatic logic [31:0] exp_perf(input int unsigned lat);
`ifdef VADD_SEQ_PERF_EN
      return lat;
`else
      return (lat == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic push_job(input job_t j);
      logic [11:0] ra, rb, rd;
      for (int unsigned i = 0; i < j.len; i++) begin
         ra = j.a + 12'(i);
         rb = j.b + 12'(i);
         rd = j.d + 12'(i);
         rd_q.push_back({ra, rb});
         wr_q.push_back(rd);
      end
   endtask

   task automatic drive_cmd(input job_t j);
      bus.cmd_a_base = j.a;
      bus.cmd_b_base = j.b;
      bus.cmd_d_base = j.d;
      bus.cmd_len    = j.len;
      bus.cmd_valid  = 1'b1;
   endtask

   task automatic wait_done(input int unsigned target);
      for (int k = 0; k < 400 && done_cnt < target; k++) begin
         @(posedge clk); #1;
      end
      if (done_cnt < target) chk("done_timeout", done_cnt, target);
   endtask

   task automatic run_job(input job_t j, input string tag);
      int unsigned d0;
      chk({tag, "_cmd_ready_before"}, {31'd0, bus.cmd_ready}, 32'd1);
      push_job(j);
      drive_cmd(j);
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      wait_done(d0 + 1);
      chk({tag, "_done_latency"}, last_done - last_acc, j.done_lat);
      chk({tag, "_cmd_ready_after"}, {31'd0, bus.cmd_ready}, 32'd1);
      chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_perf"}, bus.perf_cycles, exp_perf(j.done_lat));
      chk({tag, "_sb_empty"}, rd_q.size() + wr_q.size(), 32'd0);
   endtask

   initial begin
      job_t j1, j2;
      int unsigned n0, d0, acc1, done1;

      // done latency = len + RD_LAT + adder latency + 1 (DONE cycle); len=0 -> 1
      tbl[0] = '{a: 12'h010, b: 12'h200, d: 12'h300, len: 12'd4, done_lat: 18};
      tbl[1] = '{a: 12'h123, b: 12'h456, d: 12'h789, len: 12'd0, done_lat: 1};
      tbl[2] = '{a: 12'hFFE, b: 12'h100, d: 12'hFFD, len: 12'd4, done_lat: 18};
      tbl[3] = '{a: 12'h005, b: 12'h006, d: 12'h007, len: 12'd1, done_lat: 15};
      tbl[4] = '{a: 12'h800, b: 12'hFFA, d: 12'h400, len: 12'd9, done_lat: 23};

      bus.cmd_valid  = 1'b0;
      bus.cmd_a_base = '0;
      bus.cmd_b_base = '0;
      bus.cmd_d_base = '0;
      bus.cmd_len    = '0;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
      chk("rst_add_in_valid", {31'd0, bus.add_in_valid}, 32'd0);
      chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_perf", bus.perf_cycles, 32'd0);
      chk("rst_addrs", {bus.rd_a_addr, bus.rd_b_addr, bus.wr_addr[7:0]}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         run_job(tbl[i], $sformatf("job%0d", i));
         @(posedge clk); #1;
      end
      chk("jobs_err", {31'd0, bus.err}, 32'd0);

      // spurious adder result while IDLE
      inject = 1'b1;
      #3;
      chk("spur_wr_en", {31'd0, bus.wr_en}, 32'd0);
      @(posedge clk); #1;
      inject = 1'b0;
      chk("spur_err_set", {31'd0, bus.err}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("spur_err_sticky", {31'd0, bus.err}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("spur_err_cleared", {31'd0, bus.err}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // reset asserted at cycle 3 of a len=8 job
      j1 = '{a: 12'h020, b: 12'h220, d: 12'h320, len: 12'd8, done_lat: 22};
      push_job(j1);
      drive_cmd(j1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      rd_q.delete();
      wr_q.delete();
      chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("abort_rd_en", {31'd0, bus.rd_en}, 32'd0);
      chk("abort_add_in_valid", {31'd0, bus.add_in_valid}, 32'd0);
      chk("abort_rd_addr", {20'd0, bus.rd_a_addr}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int p = 0; p < 3; p++) begin
         repeat (2) @(posedge clk);
         #1;
         inject = 1'b1;
         @(posedge clk); #1;
         inject = 1'b0;
      end
      repeat (15) @(posedge clk);
      #1;
      chk("abort_late_err", {31'd0, bus.err}, 32'd0);
      run_job(tbl[0], "post_abort");
      chk("post_abort_err", {31'd0, bus.err}, 32'd0);
      @(posedge clk); #1;

      // back-to-back: second command held valid during the first job
      j1 = '{a: 12'h040, b: 12'h080, d: 12'h0C0, len: 12'd3, done_lat: 17};
      j2 = '{a: 12'h050, b: 12'h090, d: 12'h0C3, len: 12'd5, done_lat: 19};
      push_job(j1);
      push_job(j2);
      n0 = acc_cnt;
      d0 = done_cnt;
      drive_cmd(j1);
      @(posedge clk); #1;
      acc1 = last_acc;
      drive_cmd(j2);
      for (int k = 0; k < 200 && acc_cnt < n0 + 2; k++) begin
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
      chk("b2b_accepts", acc_cnt, n0 + 2);
      done1 = last_done;
      chk("b2b_done1_latency", done1 - acc1, j1.done_lat);
      chk("b2b_accept2_gap", last_acc - done1, 32'd1);
      wait_done(d0 + 2);
      chk("b2b_done2_latency", last_done - last_acc, j2.done_lat);
      chk("b2b_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("b2b_perf", bus.perf_cycles, exp_perf(j2.done_lat));
      chk("b2b_sb_empty", rd_q.size() + wr_q.size(), 32'd0);
      chk("b2b_err", {31'd0, bus.err}, 32'd0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
      $fatal(1);
   end

endmodule

// File: doc/vector_add_seq_ctrl.md
Name: vector_add_seq_ctrl

Overview:
- Sequences one elementwise add job over N 512-bit rows through the 16-lane fp32 `vector_add` pipeline.
- Takes a command: source A base, source B base, destination base, row count.
- Issues the paired operand-buffer reads and generates `vector_input_valid` aligned to read-data return.
- Turns `vector_output_valid` pulses into destination-buffer write addresses, then signals job completion.
- Controller only; the 512-bit data wires directly buffer→adder→buffer.

Parameters:
- ADDR_W, 12, row address width of the A, B and D buffers.
- LEN_W, 12, width of the row count.
- RD_LAT, 2, read latency in cycles of the operand buffers (≥1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready.
- cmd_a_base  in  ADDR_W  source A start row.
- cmd_b_base  in  ADDR_W  source B start row.
- cmd_d_base  in  ADDR_W  destination start row.
- cmd_len  in  LEN_W  rows to process.
- rd_en  out  1  read strobe, shared by A and B buffers.
- rd_a_addr  out  ADDR_W  source A read address.
- rd_b_addr  out  ADDR_W  source B read address.
- add_in_valid  out  1  drives `vector_input_valid`.
- add_out_valid  in  1  from `vector_output_valid`.
- wr_en  out  1  destination write strobe, equal to add_out_valid while BUSY/DRAIN.
- wr_addr  out  ADDR_W  destination row address.
- done  out  1  one-cycle job-complete pulse.
- err  out  1  sticky protocol error.
- perf_cycles  out  32  job cycle count; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=1; rd_en=0, add_in_valid=0, wr_en=0, done=0, err=0, perf_cycles=0; all addresses 0; counters and the valid delay line cleared.
- Reset asserted mid-job: abort immediately. No further rd_en or wr_en. In-flight adder results after reset are ignored; they do not set err.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On accept, latch the three bases and cmd_len; clear issue_cnt, wr_cnt and outstanding.
  - cmd_len≠0 → ISSUE.
  - cmd_len=0 → DONE.
- ISSUE:
  - Each cycle: rd_en=1, rd_a_addr=a_base+issue_cnt, rd_b_addr=b_base+issue_cnt; issue_cnt++.
  - When the last row (issue_cnt=len-1) is issued → DRAIN.
  - One row per cycle, no bubbles.
- add_in_valid: rd_en delayed by exactly RD_LAT cycles through a shift register. The shift register also runs in DRAIN and DONE.
- outstanding (LEN_W+1 bits): +1 per rd_en, −1 per accepted add_out_valid; simultaneous +1 and −1 leaves it unchanged.
- Result acceptance: on add_out_valid in ISSUE or DRAIN:
  - wr_en=1 (combinational from add_out_valid); wr_addr=d_base+wr_cnt (combinational); wr_cnt++.
- DRAIN → DONE on the cycle add_out_valid brings outstanding from 1 to 0.
- DONE: done=1 for one cycle, then → IDLE (cmd_ready=1 the following cycle).
- Address arithmetic is modulo 2^ADDR_W; base+offset wraps silently.
- err is set (sticky until reset) by add_out_valid in IDLE or DONE, or with outstanding=0. In that case wr_en is suppressed.
- The adder latency is not a parameter; completion is count-based, so any fixed adder latency works.

Optional Feature:
- Macro VADD_SEQ_PERF_EN.
- Defined: a 32-bit counter clears on accept and increments every cycle in ISSUE, DRAIN and DONE. Its value is latched to perf_cycles on the DONE cycle and held until the next DONE; the counter saturates at 2^32-1.
- Undefined: no counter; perf_cycles is tied to 0.

Test Plan:
- Basic job, RD_LAT=2, adder model latency 11. Accept at cycle 0 with a=0x010, b=0x200, d=0x300, len=4.
  - rd_en cycles 1–4, addresses 0x010–0x013 / 0x200–0x203.
  - add_in_valid cycles 3–6.
  - wr_en cycles 14–17, wr_addr 0x300–0x303.
  - done at cycle 18, cmd_ready=1 at 19; with macro, perf_cycles=18.
- len=0: accept → no rd_en, no wr_en; done one cycle later; back in IDLE the next cycle.
- Wrap: a=0xFFE, len=4 (ADDR_W=12) → rd_a_addr 0xFFE, 0xFFF, 0x000, 0x001; wr_addr wraps likewise.
- Spurious add_out_valid while IDLE → err=1, wr_en=0; err held until rst_n=0.
- rst_n low at cycle 3 of a len=8 job → all outputs reset values asynchronously; later adder pulses cause no wr_en and no err; next command runs cleanly.
- Back-to-back: second cmd_valid held high during a job → accepted only on the cycle after done. Both jobs' write addresses are correct with no overlap.
